// File: rtl/aes_ks_pkg.sv
// Shared definitions for the AES-128 round-key scheduler: round count, rcon
// end points, FSM encoding and the rcon stepping functions.
package aes_ks_pkg;

    localparam int         AES_NR     = 10;
    localparam logic [7:0] RCON_LAST  = 8'h36;
    localparam logic [7:0] RCON_FIRST = 8'h01;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } ks_state_e;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // Undoes xtime: a set LSB means the 0x11b reduction was applied going forward.
    function automatic logic [7:0] inv_xtime(input logic [7:0] x);
        return x[0] ? ({1'b0, x[7:1]} ^ 8'h8d) : {1'b0, x[7:1]};
    endfunction

endpackage

// File: rtl/aes_inv_key_sched_word_xform.sv
// RotWord + SubWord + rcon injection on one 32-bit word (byte 0 is the MSB).
// Used by both schedule directions.
module aes_ks_word_xform (
    input  logic [0:31] w,
    input  logic [7:0]  rcon,
    output logic [0:31] y
);

    logic [7:0] s0, s1, s2, s3;

    aes_sbox u_sb0 (.hi(w[8:11]),  .lo(w[12:15]), .sb(s0));
    aes_sbox u_sb1 (.hi(w[16:19]), .lo(w[20:23]), .sb(s1));
    aes_sbox u_sb2 (.hi(w[24:27]), .lo(w[28:31]), .sb(s2));
    aes_sbox u_sb3 (.hi(w[0:3]),   .lo(w[4:7]),   .sb(s3));

    // Rotated substitution with rcon folded into the leading byte.
    always_comb begin
        y = {s0, s1, s2, s3} ^ {rcon, 24'h000000};
    end

endmodule

// File: rtl/aes_sbox.sv
// AES forward S-box, byte addressed as high/low nibble.
// Computed as GF(2^8) inversion (x^254) followed by the affine transform.
module aes_sbox
    import aes_ks_pkg::*;
(
    input  logic [3:0] hi,
    input  logic [3:0] lo,
    output logic [7:0] sb
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            else      p = p;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse; it maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] sbox_f(input logic [7:0] x);
        logic [7:0] x2, x3, x12, x15, x240, inv;
        x2   = gf_mul(x, x);
        x3   = gf_mul(x2, x);
        x12  = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
        x15  = gf_mul(x12, x3);
        x240 = gf_mul(x15, x15);
        x240 = gf_mul(x240, x240);
        x240 = gf_mul(x240, x240);
        x240 = gf_mul(x240, x240);
        inv  = gf_mul(gf_mul(x240, x12), x2);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    // Pure combinational lookup.
    always_comb begin
        sb = sbox_f({hi, lo});
    end

endmodule

// File: rtl/aes_inv_key_sched.sv
// Iterative AES-128 key schedule emitting round keys 10..0 with a valid/ready handshake.
// Optional macro AES_KS_FWD_EN adds a fwd port for the forward (0..10) direction.
module aes_inv_key_sched
    import aes_ks_pkg::*;
#(
    parameter int NR = AES_NR,
    parameter int KW = 128
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [0:KW-1] key_in,
`ifdef AES_KS_FWD_EN
    input  logic          fwd,
`endif
    output logic [0:KW-1] rk_out,
    output logic [3:0]    rk_round,
    output logic          rk_valid,
    input  logic          rk_ready,
    output logic          busy,
    output logic          done
);

    ks_state_e     state_r, state_s;
    logic [7:0]    rcon_r;
    logic          dir_r;
    logic          fwd_s;
    logic          accept_s;
    logic          last_s;
    logic [0:31]   w0_s, w1_s, w2_s, w3_s, t3_s;
    logic [0:31]   xf_in_s, xf_out_s, f0_s, f1_s, f2_s;
    logic [0:KW-1] next_key_s;

`ifdef AES_KS_FWD_EN
    assign fwd_s = fwd;

    // Direction is latched with start and held for the whole sequence.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir_r <= 1'b0;
        end else if (state_r == IDLE && start) begin
            dir_r <= fwd;
        end
    end
`else
    assign fwd_s = 1'b0;
    assign dir_r = 1'b0;
`endif

    aes_ks_word_xform u_xform (.w(xf_in_s), .rcon(rcon_r), .y(xf_out_s));

    // Next round key: inverse step rebuilds w3' first because w0' depends on it.
    always_comb begin
        w0_s = rk_out[0:31];
        w1_s = rk_out[32:63];
        w2_s = rk_out[64:95];
        w3_s = rk_out[96:127];
        t3_s = w3_s ^ w2_s;
        if (dir_r) xf_in_s = w3_s;
        else       xf_in_s = t3_s;
        f0_s = w0_s ^ xf_out_s;
        f1_s = w1_s ^ f0_s;
        f2_s = w2_s ^ f1_s;
        if (dir_r) next_key_s = {f0_s, f1_s, f2_s, w3_s ^ f2_s};
        else       next_key_s = {f0_s, w1_s ^ w0_s, w2_s ^ w1_s, t3_s};
    end

    // Handshake decode and next-state logic.
    always_comb begin
        state_s  = state_r;
        accept_s = (state_r == EMIT) && rk_ready;
        if (dir_r) last_s = (rk_round == 4'(NR));
        else       last_s = (rk_round == 4'd0);
        case (state_r)
            IDLE: begin
                if (start) state_s = EMIT;
                else       state_s = IDLE;
            end
            EMIT: begin
                if (accept_s && last_s) state_s = IDLE;
                else                    state_s = EMIT;
            end
            default: state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_r <= IDLE;
        else        state_r <= state_s;
    end

    // Registered key, round index, rcon and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rk_out   <= '0;
            rk_round <= 4'd0;
            rk_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            rcon_r   <= RCON_LAST;
        end else begin
            done <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        rk_out   <= key_in;
                        rk_valid <= 1'b1;
                        busy     <= 1'b1;
                        rk_round <= fwd_s ? 4'd0 : 4'(NR);
                        rcon_r   <= fwd_s ? RCON_FIRST : RCON_LAST;
                    end
                end
                EMIT: begin
                    if (accept_s && last_s) begin
                        rk_valid <= 1'b0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                    end else if (accept_s) begin
                        rk_out   <= next_key_s;
                        rk_round <= dir_r ? (rk_round + 4'd1) : (rk_round - 4'd1);
                        rcon_r   <= dir_r ? xtime(rcon_r) : inv_xtime(rcon_r);
                    end
                end
                default: begin
                    rk_valid <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_inv_key_sched.sv
// Scoreboard bench: a word-array AES key expansion model queues the expected
// round keys; a negedge monitor pops and compares on every accepted handshake.
module tb_aes_inv_key_sched;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [127:0] key_in = '0;
    logic         fwd = 1'b0;
    logic [127:0] rk_out;
    logic [3:0]   rk_round;
    logic         rk_valid;
    logic         rk_ready = 1'b0;
    logic         busy;
    logic         done;

    aes_inv_key_sched dut (
        .clk(clk), .rst_n(rst_n), .start(start), .key_in(key_in),
`ifdef AES_KS_FWD_EN
        .fwd(fwd),
`endif
        .rk_out(rk_out), .rk_round(rk_round), .rk_valid(rk_valid),
        .rk_ready(rk_ready), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   rnd;
        logic [127:0] key;
        logic [7:0]   rcon;
        bit           rcon_chk;
    } exp_t;

    exp_t         exp_q[$];
    int           n_cmp = 0;
    int           n_bad = 0;
    int           done_cnt = 0;
    int           cyc_no = 0;
    int           first_acc = 0;
    int           last_acc = 0;
    int           acc_n = 0;
    logic [127:0] got_rk [16];
    logic [127:0] t1_rk  [11];
    logic [7:0]   sbox_tbl [256];
    logic [31:0]  wm [44];
    logic [7:0]   rcon_tbl [11] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    logic [127:0] sb_rows [16] = '{
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

    localparam logic [127:0] K_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] K_R9  = 128'hac7766f319fadc2128d12941575c006e;
    localparam logic [127:0] K_R0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] sub_rot(input logic [31:0] w);
        return {sbox_tbl[w[23:16]], sbox_tbl[w[15:8]], sbox_tbl[w[7:0]], sbox_tbl[w[31:24]]};
    endfunction

    // FIPS-197 word recurrence w[i] = w[i-4] ^ g(w[i-1]), run forwards or solved backwards.
    task automatic model_push(input logic [127:0] key, input bit f);
        logic [31:0] t;
        exp_t e;
        for (int j = 0; j < 4; j++) begin
            if (f) wm[j]      = key[127-32*j -: 32];
            else   wm[40 + j] = key[127-32*j -: 32];
        end
        if (f) begin
            for (int i = 4; i < 44; i++) begin
                t = wm[i-1];
                if (i % 4 == 0) t = sub_rot(t) ^ {rcon_tbl[i/4], 24'h0};
                wm[i] = wm[i-4] ^ t;
            end
        end else begin
            for (int i = 43; i >= 4; i--) begin
                t = wm[i-1];
                if (i % 4 == 0) t = sub_rot(t) ^ {rcon_tbl[i/4], 24'h0};
                wm[i-4] = wm[i] ^ t;
            end
        end
        for (int k = 0; k < 11; k++) begin
            int r;
            r = f ? k : 10 - k;
            e.rnd = 4'(r);
            e.key = {wm[4*r], wm[4*r+1], wm[4*r+2], wm[4*r+3]};
            e.rcon_chk = f ? (r < 10) : (r > 0);
            e.rcon = f ? ((r < 10) ? rcon_tbl[r+1] : 8'h00) : rcon_tbl[r];
            exp_q.push_back(e);
        end
    endtask

    always @(posedge clk) cyc_no++;

    // Monitor: scoreboard pop on accept, stall stability, done counting.
    logic         prev_stall = 1'b0;
    logic [127:0] prev_out;
    logic [3:0]   prev_rnd;
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (done) done_cnt++;
            if (prev_stall && rk_valid) begin
                chk("stall_key_stable", rk_out, prev_out);
                chk("stall_round_stable", 128'(rk_round), 128'(prev_rnd));
            end
            if (rk_valid && rk_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_key", 128'(rk_round), 128'hffff);
                end else begin
                    e = exp_q.pop_front();
                    chk("rk_round", 128'(rk_round), 128'(e.rnd));
                    chk("rk_out", rk_out, e.key);
                    chk("busy_during_emit", 128'(busy), 128'd1);
                    if (e.rcon_chk) chk("rcon_trace", 128'(dut.rcon_r), 128'(e.rcon));
                    got_rk[rk_round] = rk_out;
                    if (acc_n == 0) first_acc = cyc_no;
                    last_acc = cyc_no;
                    acc_n++;
                end
            end
            prev_stall = rk_valid && !rk_ready;
            prev_out   = rk_out;
            prev_rnd   = rk_round;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic run_seq(input logic [127:0] key, input bit f, input bit rnd_ready, input bit pulse7);
        int base, cyc, stall;
        bit pulsed;
        model_push(key, f);
        base = done_cnt;
        acc_n = 0;
        key_in = key; fwd = f; start = 1'b1; rk_ready = !rnd_ready;
        @(posedge clk); #1;
        start = 1'b0;
        chk("latency_valid", 128'(rk_valid), 128'd1);
        chk("first_round", 128'(rk_round), f ? 128'd0 : 128'd10);
        cyc = 0; stall = 0; pulsed = 1'b0;
        while (!done && cyc < 300) begin
            if (!rnd_ready) rk_ready = 1'b1;
            else if (rk_valid && rk_round == 4'd5 && stall < 5) begin
                rk_ready = 1'b0;
                stall++;
            end else rk_ready = 1'($urandom_range(0, 1));
            if (pulse7 && !pulsed && rk_valid && rk_round == 4'd7) begin
                start = 1'b1; key_in = {$urandom, $urandom, $urandom, $urandom}; pulsed = 1'b1;
            end else start = 1'b0;
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0; rk_ready = 1'b0;
        chk("done_seen", 128'(done), 128'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("done_count", 128'(done_cnt - base), 128'd1);
        chk("queue_drained", 128'(exp_q.size()), 128'd0);
        chk("idle_not_busy", 128'(busy), 128'd0);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, cyc;
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++)
                sbox_tbl[r*16+c] = sb_rows[r][127-8*c -: 8];

        repeat (3) @(posedge clk);
        #1;
        chk("rst_rk_out", rk_out, 128'h0);
        chk("rst_rk_round", 128'(rk_round), 128'd0);
        chk("rst_rk_valid", 128'(rk_valid), 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_done", 128'(done), 128'd0);
        chk("rst_rcon", 128'(dut.rcon_r), 128'h36);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // T1: full-rate inverse run
        run_seq(K_R10, 1'b0, 1'b0, 1'b0);
        chk("t1_round9", got_rk[9], K_R9);
        chk("t1_round0", got_rk[0], K_R0);
        chk("t1_burst_cycles", 128'(last_acc - first_acc), 128'd10);
        for (int r = 0; r < 11; r++) t1_rk[r] = got_rk[r];

        // T2: random backpressure with a 5-cycle stall at round 5
        run_seq(K_R10, 1'b0, 1'b1, 1'b0);
        for (int r = 0; r < 11; r++) chk("t2_same_as_t1", got_rk[r], t1_rk[r]);

        // T3: start while busy must be ignored
        run_seq(K_R10, 1'b0, 1'b0, 1'b1);
        chk("t3_round0", got_rk[0], K_R0);

        // T4: asynchronous reset mid-sequence
        model_push(K_R10, 1'b0);
        base = done_cnt;
        key_in = K_R10; fwd = 1'b0; start = 1'b1; rk_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; cyc = 0;
        while (!(rk_valid && rk_round == 4'd4) && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("t4_reached_round4", 128'(rk_round), 128'd4);
        #2 rst_n = 1'b0;
        #1;
        chk("t4_rk_out", rk_out, 128'h0);
        chk("t4_rk_round", 128'(rk_round), 128'd0);
        chk("t4_rk_valid", 128'(rk_valid), 128'd0);
        chk("t4_busy", 128'(busy), 128'd0);
        chk("t4_done", 128'(done), 128'd0);
        exp_q.delete();
        rk_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("t4_no_done", 128'(done_cnt - base), 128'd0);
        run_seq(K_R10, 1'b0, 1'b0, 1'b0);
        chk("t4_rerun_round0", got_rk[0], K_R0);

`ifdef AES_KS_FWD_EN
        // T5: forward direction from the cipher key
        run_seq(K_R0, 1'b1, 1'b0, 1'b0);
        chk("t5_round10", got_rk[10], K_R10);
        fwd = 1'b0;
`endif

        // T6: all-zero key, rcon trace checked by the monitor
        run_seq(128'h0, 1'b0, 1'b0, 1'b0);
        chk("t6_first_key", got_rk[10], 128'h0);

        // Extra random inverse runs
        for (int k = 0; k < 3; k++)
            run_seq({$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
